// File: rtl/mem_responder.sv
// mem_responder: memory-side responder shared by the instruction cache
// (device 0, read-only) and the data cache (device 1, read/write).
// Level-held requests are arbitrated round-robin, each access is issued to a
// synchronous single-port RAM, and read data returns on the shared mem_do bus
// with a one-cycle per-device ack. Incrementing burst reads are supported.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   device_1_mem_addr          icache word address (device 0)
//   device_2_mem_addr/_mem_di  dcache word address / write data (device 1)
//   device_2_bank_select       dcache byte-lane enables for writes
//   devices_burst_en/_mem_we   per-device burst / write request (we[0] ignored)
//   devices_mem_en             per-device request, held until final ack
//   devices_do_ack             per-device one-cycle completion/beat strobe
//   mem_do                     read data, valid while an ack bit is high
//   ram_*                      RAM address, write data, byte enables, strobes
//   ram_do                     RAM read data, RAM_LATENCY cycles after ram_en
module mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] device_1_mem_addr,
   input  logic [ADDR_WIDTH-1:0] device_2_mem_addr,
   input  logic [DATA_WIDTH-1:0] device_2_mem_di,
   input  logic [3:0]            device_2_bank_select,
   input  logic [1:0]            devices_burst_en,
   input  logic [1:0]            devices_mem_we,
   input  logic [1:0]            devices_mem_en,
   output logic [1:0]            devices_do_ack,
   output logic [DATA_WIDTH-1:0] mem_do,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_di,
   output logic [3:0]            ram_be,
   output logic                  ram_we,
   output logic                  ram_en,
   input  logic [DATA_WIDTH-1:0] ram_do
);

   localparam int unsigned BEAT_W = (BURST_LEN > 1)   ? $clog2(BURST_LEN)   : 1;
   localparam int unsigned LAT_W  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RECOVER} state_t;

   state_t                state, state_d;
   logic                  last_grant, last_grant_d;   // also the current grant once latched
   logic [ADDR_WIDTH-1:0] addr, addr_d;
   logic [DATA_WIDTH-1:0] di, di_d;
   logic [3:0]            be, be_d;
   logic                  we, we_d;
   logic                  burst, burst_d;
   logic [BEAT_W-1:0]     beat, beat_d;
   logic [LAT_W-1:0]      lat, lat_d;

   logic [1:0]            ack_d;
   logic [DATA_WIDTH-1:0] mem_do_d;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_di_d;
   logic [3:0]            ram_be_d;
   logic                  ram_we_d;
   logic                  ram_en_d;

   // The icache is read-only, so its write-request bit carries no meaning.
   logic unused_we0;
   assign unused_we0 = devices_mem_we[0];

   // State, request latches and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         addr           <= '0;
         di             <= '0;
         be             <= '0;
         we             <= 1'b0;
         burst          <= 1'b0;
         beat           <= '0;
         lat            <= '0;
         devices_do_ack <= '0;
         mem_do         <= '0;
         ram_addr       <= '0;
         ram_di         <= '0;
         ram_be         <= '0;
         ram_we         <= 1'b0;
         ram_en         <= 1'b0;
      end else begin
         state          <= state_d;
         last_grant     <= last_grant_d;
         addr           <= addr_d;
         di             <= di_d;
         be             <= be_d;
         we             <= we_d;
         burst          <= burst_d;
         beat           <= beat_d;
         lat            <= lat_d;
         devices_do_ack <= ack_d;
         mem_do         <= mem_do_d;
         ram_addr       <= ram_addr_d;
         ram_di         <= ram_di_d;
         ram_be         <= ram_be_d;
         ram_we         <= ram_we_d;
         ram_en         <= ram_en_d;
      end
   end

   // Next state, request latching, and output values for the state being entered.
   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      addr_d       = addr;
      di_d         = di;
      be_d         = be;
      we_d         = we;
      burst_d      = burst;
      beat_d       = beat;
      lat_d        = lat;

      case (state)
         IDLE: begin
            if (|devices_mem_en) begin
               // On a tie the device that was not served last wins.
               if (devices_mem_en == 2'b11) last_grant_d = ~last_grant;
               else                         last_grant_d = devices_mem_en[1];
               if (last_grant_d) begin
                  addr_d  = device_2_mem_addr;
                  di_d    = device_2_mem_di;
                  we_d    = devices_mem_we[1];
                  be_d    = devices_mem_we[1] ? device_2_bank_select : 4'b1111;
                  burst_d = devices_burst_en[1];
               end else begin
                  addr_d  = device_1_mem_addr;
                  di_d    = '0;
                  we_d    = 1'b0;
                  be_d    = 4'b1111;
                  burst_d = devices_burst_en[0];
               end
               beat_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            lat_d   = '0;
            state_d = we ? ACK : WAIT;
         end
         WAIT: begin
            if (lat == LAT_W'(RAM_LATENCY - 1)) state_d = ACK;
            else                                lat_d   = lat + LAT_W'(1);
         end
         ACK: begin
            // A write with burst_en falls through here as a single access.
            if (burst && !we && (beat < BEAT_W'(BURST_LEN - 1)) && devices_mem_en[last_grant]) begin
               addr_d  = addr + ADDR_WIDTH'(1);
               beat_d  = beat + BEAT_W'(1);
               state_d = ISSUE;
            end else begin
               state_d = RECOVER;
            end
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are computed for state_d.
      ram_en_d   = (state_d == ISSUE);
      ram_we_d   = ram_en_d & we_d;
      ram_be_d   = ram_en_d ? be_d : 4'b0000;
      ram_addr_d = ram_en_d ? addr_d : ram_addr;
      ram_di_d   = ram_en_d ? di_d : ram_di;
      ack_d      = 2'b00;
      if (state_d == ACK) ack_d = last_grant_d ? 2'b10 : 2'b01;
      // mem_do only changes on read completion; writes leave it untouched.
      mem_do_d   = mem_do;
      if ((state == WAIT) && (state_d == ACK)) mem_do_d = ram_do;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: behavioural synchronous RAM, directed stimulus
// that pushes expected acks into a scoreboard queue, and a monitor that pops
// and compares device, data and cycle whenever an ack is presented.
module tb_mem_responder;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned BL = 4;
   localparam int unsigned RL = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] device_1_mem_addr;
   logic [AW-1:0] device_2_mem_addr;
   logic [DW-1:0] device_2_mem_di;
   logic [3:0]    device_2_bank_select;
   logic [1:0]    devices_burst_en;
   logic [1:0]    devices_mem_we;
   logic [1:0]    devices_mem_en;
   logic [1:0]    devices_do_ack;
   logic [DW-1:0] mem_do;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_di;
   logic [3:0]    ram_be;
   logic          ram_we;
   logic          ram_en;
   logic [DW-1:0] ram_do;

   mem_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL),
      .RAM_LATENCY(RL)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .device_1_mem_addr   (device_1_mem_addr),
      .device_2_mem_addr   (device_2_mem_addr),
      .device_2_mem_di     (device_2_mem_di),
      .device_2_bank_select(device_2_bank_select),
      .devices_burst_en    (devices_burst_en),
      .devices_mem_we      (devices_mem_we),
      .devices_mem_en      (devices_mem_en),
      .devices_do_ack      (devices_do_ack),
      .mem_do              (mem_do),
      .ram_addr            (ram_addr),
      .ram_di              (ram_di),
      .ram_be              (ram_be),
      .ram_we              (ram_we),
      .ram_en              (ram_en),
      .ram_do              (ram_do)
   );

   always #5 clk = ~clk;

   // Single-cycle synchronous RAM model with byte-lane writes.
   logic [DW-1:0] ram [0:65535];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
         end else begin
            ram_do <= ram[ram_addr];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  ack;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] ack, input logic [31:0] data, input int c);
      exp_t e;
      e.ack  = ack;
      e.data = data;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   // Monitor: every ack must match the head of the scoreboard.
   always @(negedge clk) begin
      if (devices_do_ack != 2'b00) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 64'(devices_do_ack), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("ack_dev", 64'(devices_do_ack), 64'(mon_e.ack));
            check("ack_data", 64'(mem_do), 64'(mon_e.data));
            check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   // Wait for n acks on one device, then drop that device's request.
   task automatic wait_ack(input int dev, input int n);
      int cnt = 0;
      for (int i = 0; i < 100 && cnt < n; i++) begin
         @(negedge clk);
         if (devices_do_ack[dev]) cnt++;
      end
      check("ack_count", 64'(cnt), 64'(n));
      devices_mem_en[dev] = 1'b0;
   endtask

   // Let RECOVER pass so the next drive lands in an IDLE sampling cycle.
   task automatic gap();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ack"},      64'(devices_do_ack), 64'd0);
      check({tag, "_mem_do"},   64'(mem_do),         64'd0);
      check({tag, "_ram_addr"}, 64'(ram_addr),       64'd0);
      check({tag, "_ram_di"},   64'(ram_di),         64'd0);
      check({tag, "_ram_be"},   64'(ram_be),         64'd0);
      check({tag, "_ram_we"},   64'(ram_we),         64'd0);
      check({tag, "_ram_en"},   64'(ram_en),         64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   int c0;

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = {16'h5A5A, 16'(i)};
      ram[16'h0010] = 32'hDEADBEEF;
      ram[16'h0200] = 32'h11223344;
      ram[16'h0300] = 32'h55667788;
      ram[16'hFFFE] = 32'hA000FFFE;
      ram[16'hFFFF] = 32'hA000FFFF;
      ram[16'h0000] = 32'hA0000000;
      ram[16'h0001] = 32'hA0000001;
      ram[16'h0040] = 32'hB0000040;
      ram[16'h0041] = 32'hB0000041;
      ram[16'h0050] = 32'hC0000050;
      ram[16'h0060] = 32'hD0000060;
      ram[16'h0070] = 32'hE0000070;
      ram[16'h0080] = 32'hE0000080;
      ram_do = '0;

      reset                = 1'b1;
      device_1_mem_addr    = '0;
      device_2_mem_addr    = '0;
      device_2_mem_di      = '0;
      device_2_bank_select = '0;
      devices_burst_en     = '0;
      devices_mem_we       = '0;
      devices_mem_en       = '0;

      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Device 0 single read.
      c0 = cyc;
      device_1_mem_addr = 16'h0010;
      devices_mem_en    = 2'b01;
      push(2'b01, 32'hDEADBEEF, c0 + 3);
      @(negedge clk);
      check("rd_ram_en_c1", 64'(ram_en), 64'd1);
      check("rd_ram_addr_c1", 64'(ram_addr), 64'h0010);
      check("rd_ram_we_c1", 64'(ram_we), 64'd0);
      @(negedge clk);
      check("rd_ram_en_c2", 64'(ram_en), 64'd0);
      wait_ack(0, 1);
      gap();

      // Device 1 partial write; mem_do keeps the last read data.
      c0 = cyc;
      device_2_mem_addr    = 16'h0200;
      device_2_mem_di      = 32'hCAFEF00D;
      device_2_bank_select = 4'b0011;
      devices_mem_we       = 2'b10;
      devices_mem_en       = 2'b10;
      push(2'b10, 32'hDEADBEEF, c0 + 2);
      @(negedge clk);
      check("wr_ram_en", 64'(ram_en), 64'd1);
      check("wr_ram_we", 64'(ram_we), 64'd1);
      check("wr_ram_be", 64'(ram_be), 64'b0011);
      check("wr_ram_di", 64'(ram_di), 64'hCAFEF00D);
      wait_ack(1, 1);
      gap();

      // Read back: only the low 16 bits took the new data.
      c0 = cyc;
      devices_mem_we = 2'b00;
      devices_mem_en = 2'b10;
      push(2'b10, 32'h1122F00D, c0 + 3);
      wait_ack(1, 1);
      gap();

      // Write with zero byte enables and burst_en: one ack, RAM unchanged.
      c0 = cyc;
      device_2_mem_addr    = 16'h0300;
      device_2_mem_di      = 32'hFFFFFFFF;
      device_2_bank_select = 4'b0000;
      devices_burst_en     = 2'b10;
      devices_mem_we       = 2'b10;
      devices_mem_en       = 2'b10;
      push(2'b10, 32'h1122F00D, c0 + 2);
      @(negedge clk);
      check("wr0_ram_we", 64'(ram_we), 64'd1);
      check("wr0_ram_be", 64'(ram_be), 64'd0);
      wait_ack(1, 1);
      devices_burst_en = 2'b00;
      devices_mem_we   = 2'b00;
      gap();

      c0 = cyc;
      devices_mem_en = 2'b10;
      push(2'b10, 32'h55667788, c0 + 3);
      wait_ack(1, 1);
      gap();

      // Device 0 burst wrapping past the top of the address space; we[0] ignored.
      c0 = cyc;
      device_1_mem_addr = 16'hFFFE;
      devices_burst_en  = 2'b01;
      devices_mem_we    = 2'b01;
      devices_mem_en    = 2'b01;
      push(2'b01, 32'hA000FFFE, c0 + 3);
      push(2'b01, 32'hA000FFFF, c0 + 6);
      push(2'b01, 32'hA0000000, c0 + 9);
      push(2'b01, 32'hA0000001, c0 + 12);
      wait_ack(0, 4);
      devices_mem_we = 2'b00;
      gap();

      // Burst cut short after two beats; pending device 1 is served next.
      c0 = cyc;
      device_1_mem_addr = 16'h0040;
      devices_burst_en  = 2'b01;
      devices_mem_en    = 2'b01;
      push(2'b01, 32'hB0000040, c0 + 3);
      push(2'b01, 32'hB0000041, c0 + 6);
      push(2'b10, 32'hC0000050, c0 + 11);
      @(negedge clk);
      device_2_mem_addr = 16'h0050;
      devices_mem_en    = 2'b11;
      wait_ack(0, 2);
      devices_burst_en = 2'b00;
      wait_ack(1, 1);
      gap();

      // Reset during WAIT of a read: outputs clear at once, no ack.
      c0 = cyc;
      device_2_mem_addr = 16'h0060;
      devices_mem_en    = 2'b10;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_outputs_zero("midreset");
      devices_mem_en = 2'b00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      c0 = cyc;
      devices_mem_en = 2'b10;
      push(2'b10, 32'hD0000060, c0 + 3);
      wait_ack(1, 1);
      gap();

      // Fresh reset, both requesting continuously: grants alternate from device 0.
      do_reset();
      c0 = cyc;
      device_1_mem_addr = 16'h0070;
      device_2_mem_addr = 16'h0080;
      devices_mem_en    = 2'b11;
      push(2'b01, 32'hE0000070, c0 + 3);
      push(2'b10, 32'hE0000080, c0 + 8);
      push(2'b01, 32'hE0000070, c0 + 13);
      push(2'b10, 32'hE0000080, c0 + 18);
      begin
         int cnt = 0;
         for (int i = 0; i < 100 && cnt < 4; i++) begin
            @(negedge clk);
            if (devices_do_ack != 2'b00) cnt++;
         end
         check("alt_ack_count", 64'(cnt), 64'd4);
      end
      devices_mem_en = 2'b00;
      repeat (4) @(negedge clk);

      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the two cache initiators. Device 0 is the instruction cache and is read-only. Device 1 is the data cache and can read or write.
- Arbitrates their level-held requests round-robin, performs accesses on a synchronous single-port RAM, and returns read data on a shared mem_do bus with a per-device one-cycle ack.
- Supports incrementing burst reads.

Parameters:
- ADDR_WIDTH, 16, word address width of device and RAM ports.
- DATA_WIDTH, 32, data width.
- BURST_LEN, 4, beats per burst read (>=2).
- RAM_LATENCY, 1, cycles from ram_en to valid ram_do (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- device_1_mem_addr  in  ADDR_WIDTH  icache word address
- device_2_mem_addr  in  ADDR_WIDTH  dcache word address
- device_2_mem_di  in  DATA_WIDTH  dcache write data
- device_2_bank_select  in  4  dcache byte-lane enables for writes
- devices_burst_en  in  2  per-device burst request
- devices_mem_we  in  2  per-device write request; bit 0 ignored
- devices_mem_en  in  2  per-device request, held until final ack
- devices_do_ack  out  2  per-device one-cycle completion/beat strobe
- mem_do  out  DATA_WIDTH  read data, valid when ack bit high
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_di  out  DATA_WIDTH  RAM write data
- ram_be  out  4  RAM byte enables
- ram_we  out  1  RAM write strobe
- ram_en  out  1  RAM access strobe
- ram_do  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-operation):
  - FSM goes to IDLE; no ack is emitted for an aborted access.
  - All outputs are 0: devices_do_ack, mem_do, ram_addr, ram_di, ram_be, ram_we, ram_en.
  - last_grant = 1, so device 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, ACK, RECOVER.
- IDLE:
  - If any devices_mem_en bit is set, pick the granted device g:
    - Only one bit set: that device.
    - Both set: the device other than last_grant.
  - Latch address, we, data, bank_select and burst for g.
  - Device 0 latches we=0 and be=4'b1111. Device 1 reads latch be=4'b1111; device 1 writes latch be=bank_select.
  - Set last_grant=g, clear beat counter, go to ISSUE.
- ISSUE (one cycle):
  - Drive ram_en=1, ram_addr, ram_we, ram_di, ram_be.
  - Write: go to ACK. Read: go to WAIT.
- WAIT:
  - Stay RAM_LATENCY cycles, then capture ram_do into the data register and go to ACK.
  - ram_en=0 throughout.
- ACK (one cycle):
  - devices_do_ack[g]=1.
  - On reads, mem_do = captured data. On writes, mem_do holds its previous value.
  - Burst read with beat < BURST_LEN-1 and devices_mem_en[g] still 1: address+1 (wraps to 0 at 2^ADDR_WIDTH), beat+1, go to ISSUE.
  - Otherwise go to RECOVER.
- RECOVER: one idle cycle so the initiator can drop en, then IDLE.
- Latency, counting the cycle IDLE samples en as cycle 0:
  - Write ack in cycle 2.
  - Single read ack in cycle 2+RAM_LATENCY.
  - Burst beats spaced 2+RAM_LATENCY cycles apart.
  - Next grant sampled no earlier than 2 cycles after the final ack.
- Boundary and protocol rules:
  - burst_en together with we is treated as a single write.
  - devices_mem_we[0] is ignored.
  - Write with bank_select=0: ram_we=1, ram_be=0, still acked.
  - en dropped mid-access: the current beat still completes and acks; a burst stops after that beat.
  - Inputs are sampled only in IDLE; changes during an access have no effect.
  - Exactly one bit of devices_do_ack is high at a time, and only in ACK.
  - The ungranted device waits with no ack.

Test Plan:
- Reset, then device 0 requests a read of 0x0010 with RAM[0x0010]=0xDEADBEEF → ram_en pulses in cycle 1; devices_do_ack=2'b01 with mem_do=0xDEADBEEF in cycle 3; no other acks.
- Device 1 writes 0xCAFEF00D to 0x0200 with bank_select=4'b0011 → ram_we=1, ram_be=0011 in cycle 1; ack 2'b10 in cycle 2; mem_do unchanged; a read-back returns only the low 16 bits updated.
- Both en raised in the same cycle after reset → device 0 is served first. Both held → grants alternate 0,1,0,1 over four accesses.
- Device 0 burst read at 0xFFFE, BURST_LEN=4 → four acks carrying RAM[0xFFFE], RAM[0xFFFF], RAM[0x0000], RAM[0x0001], spaced 3 cycles apart.
- Burst where device 0 drops en after its 2nd ack → exactly 2 acks, then RECOVER and IDLE; a pending device 1 request is granted next.
- reset asserted during WAIT of a read → outputs are 0 immediately and no ack appears. After release, a re-issued request completes with normal latency.
